silife_sync_sequencer: RTL

//  Sequences one inter-chip edge-sync transfer per generation for the four grid sync edges.
//  - Drives the shared sync_active/sync_clk pair, runs a fixed number of sync clock periods,

---
 rtl/silife_sync_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/silife_sync_sequencer.sv
// silife_sync_sequencer: runs one inter-chip edge-sync transfer per generation.
// Optional WAIT_BUSY timeout is enabled by defining SILIFE_SYNC_TIMEOUT_EN.
module silife_sync_sequencer #(
    parameter int SYNC_BITS      = 34,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DIV_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_enable,
    input  logic                 i_start,
    input  logic [DIV_WIDTH-1:0] i_clk_div,
    input  logic                 i_sync_busy_syn,
    output logic                 o_sync_active,
    output logic                 o_sync_clk,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

    // Wide enough to hold SYNC_BITS itself, so the final increment never wraps.
    localparam int PER_W = $clog2(SYNC_BITS + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYNC_BITS - 1);

`ifdef SILIFE_SYNC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_CLOCKING = 3'd2,
        S_WAIT     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] phase_q;
    logic [SET_W-1:0]     settle_q;
    logic [PER_W-1:0]     period_q;
    logic                 active_q;
    logic                 sclk_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sync1_q;
    logic                 busy_s_q;
`ifdef SILIFE_SYNC_TIMEOUT_EN
    logic [TMO_W-1:0]     wait_q;
    logic                 timeout_q;
`endif

    // Two-flop synchroniser for the asynchronous neighbour busy line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            busy_s_q <= 1'b0;
        end else begin
            sync1_q  <= i_sync_busy_syn;
            busy_s_q <= sync1_q;
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= '0;
            settle_q  <= '0;
            period_q  <= '0;
            active_q  <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SILIFE_SYNC_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (state_q != S_IDLE && !i_enable) begin
            // Abort: drop everything, report nothing.
            state_q   <= S_IDLE;
            phase_q   <= '0;
            settle_q  <= '0;
            period_q  <= '0;
            active_q  <= 1'b0;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SILIFE_SYNC_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    sclk_q <= 1'b0;
`ifdef SILIFE_SYNC_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    if (i_start && i_enable) begin
                        state_q  <= S_SETTLE;
                        div_q    <= i_clk_div;
                        settle_q <= '0;
                        active_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        active_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        state_q  <= S_CLOCKING;
                        settle_q <= '0;
                        phase_q  <= '0;
                        period_q <= '0;
                        sclk_q   <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end

                S_CLOCKING: begin
                    if (phase_q == div_q) begin
                        phase_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                        end else begin
                            // Low phase finished: one full period done.
                            period_q <= period_q + 1'b1;
                            if (period_q == PER_LAST) begin
                                state_q <= S_WAIT;
`ifdef SILIFE_SYNC_TIMEOUT_EN
                                wait_q  <= '0;
`endif
                            end else begin
                                sclk_q <= 1'b1;
                            end
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                S_WAIT: begin
                    sclk_q <= 1'b0;
                    if (!busy_s_q) begin
                        state_q  <= S_DONE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        period_q <= '0;
`ifdef SILIFE_SYNC_TIMEOUT_EN
                    end else if (wait_q == TMO_LAST) begin
                        state_q   <= S_DONE;
                        active_q  <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        wait_q    <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
`endif
                    end
                end

                S_DONE: begin
                    state_q  <= S_IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    active_q <= 1'b0;
`ifdef SILIFE_SYNC_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                end

                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                    sclk_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_sync_active = active_q;
    assign o_sync_clk    = sclk_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
`ifdef SILIFE_SYNC_TIMEOUT_EN
    assign o_timeout     = timeout_q;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule
